// File: rtl/glyph_pkg.sv
// Shared definitions for the glyph streamer: column width, output FSM states
// and the {column, last} FIFO entry format.
package glyph_pkg;

  localparam int COL_W = 3;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t EMIT = 2'd1;
  localparam state_t SEP  = 2'd2;

  localparam logic [COL_W-1:0] BLANK_COL = '0;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic             is_last;
  } entry_t;

endpackage

// File: rtl/column_fifo.sv
// Synchronous FIFO of packed glyph columns with a last-of-glyph flag.
// Read data is the current head entry, valid whenever the FIFO is not empty.
module column_fifo
  import glyph_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   restart,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  entry_t                 wdata_i,
  output entry_t                 rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (restart) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/glyph_streamer.sv
// Packs a serial pixel stream into 3-bit columns, buffers them, and replays
// each complete glyph gap-free on bits followed by one blank separator cycle.
module glyph_streamer
  import glyph_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             restart,
  input  logic             pixel,
  input  logic             pixel_valid,
  input  logic             pixel_last,
  output logic             pixel_ready,
  output logic [COL_W-1:0] bits,
  output logic             col_valid
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  entry_t           head, push_entry;
  logic             accept, push, pop, take;

  logic [1:0]       pix_cnt_q, pix_cnt_d;
  logic [COL_W-1:0] partial_q, partial_d, col_w;
  logic [CW-1:0]    glyph_count_q, glyph_count_d;
  state_t           state_q, state_d;
  logic [COL_W-1:0] bits_q, bits_d;
  logic             col_valid_q, col_valid_d;
  logic             shown_last_q, shown_last_d;

  assign pixel_ready = (fifo_count < CW'(DEPTH));
  assign accept      = pixel_valid && pixel_ready;
  assign bits        = bits_q;
  assign col_valid   = col_valid_q;

  // Pixel k of a column lands in bit 2-k; a short final column keeps zeros below.
  always_comb begin
    col_w = partial_q;
    case (pix_cnt_q)
      2'd0:    col_w[2] = pixel;
      2'd1:    col_w[1] = pixel;
      default: col_w[0] = pixel;
    endcase
    push       = accept && (pix_cnt_q == 2'd2 || pixel_last);
    push_entry = '{col: col_w, is_last: pixel_last};
    partial_d  = partial_q;
    pix_cnt_d  = pix_cnt_q;
    if (push) begin
      partial_d = BLANK_COL;
      pix_cnt_d = 2'd0;
    end else if (accept) begin
      partial_d = col_w;
      pix_cnt_d = pix_cnt_q + 2'd1;
    end
  end

  column_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .restart (restart),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Output defaults to blank/IDLE; take pops the head into the bits register.
  always_comb begin
    take         = 1'b0;
    state_d      = IDLE;
    bits_d       = BLANK_COL;
    col_valid_d  = 1'b0;
    shown_last_d = 1'b0;
    case (state_q)
      IDLE: take = (glyph_count_q != '0) || fifo_full;
      EMIT: begin
        if (shown_last_q) state_d = SEP;
        else              take    = !fifo_empty;
      end
      SEP:  take = (glyph_count_q != '0);
      default: take = 1'b0;
    endcase
    pop = take;
    if (take) begin
      state_d      = EMIT;
      bits_d       = head.col;
      col_valid_d  = 1'b1;
      shown_last_d = head.is_last;
    end
    glyph_count_d = glyph_count_q + CW'(push && pixel_last) - CW'(pop && head.is_last);
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      pix_cnt_q     <= 2'd0;
      partial_q     <= BLANK_COL;
      glyph_count_q <= '0;
      state_q       <= IDLE;
      bits_q        <= BLANK_COL;
      col_valid_q   <= 1'b0;
      shown_last_q  <= 1'b0;
    end else begin
      pix_cnt_q     <= pix_cnt_d;
      partial_q     <= partial_d;
      glyph_count_q <= glyph_count_d;
      state_q       <= state_d;
      bits_q        <= bits_d;
      col_valid_q   <= col_valid_d;
      shown_last_q  <= shown_last_d;
    end
  end

endmodule

// File: tb/tb_glyph_streamer.sv
// Self-checking bench for glyph_streamer: a queue-based reference model checked
// every cycle, plus literal expectations for the directed glyph scenarios.
module tb_glyph_streamer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       restart, pixel, pixel_valid, pixel_last;
  logic       pixel_ready, col_valid;
  logic [2:0] bits;

  int errors = 0;
  int checks = 0;

  // Reference model: queued {column,last} entries, pixels of the open column,
  // and what the output showed last cycle.
  bit [3:0] mQ[$];
  bit       mPix[$];
  logic [2:0] mBits;
  logic     mValid, mShownLast, mPrevSep;

  always #5 clk = ~clk;

  glyph_streamer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .restart     (restart),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .pixel_last  (pixel_last),
    .pixel_ready (pixel_ready),
    .bits        (bits),
    .col_valid   (col_valid)
  );

  function automatic int pendingGlyphs();
    int n = 0;
    foreach (mQ[i]) if (mQ[i][0]) n++;
    return n;
  endfunction

  task automatic modelReset();
    mQ.delete();
    mPix.delete();
    mBits = 3'b000;
    mValid = 1'b0;
    mShownLast = 1'b0;
    mPrevSep = 1'b0;
  endtask

  // A glyph plays until its last column, then one blank separator; after a
  // separator only a complete glyph starts output, otherwise a full buffer does too.
  task automatic modelUpdate(input logic r, input logic pv, input logic p, input logic pl);
    bit canAccept, show, sepNow;
    bit [3:0] e;
    bit [2:0] col;
    int glyphs;
    if (r) begin
      modelReset();
      return;
    end
    canAccept = pv && (mQ.size() < DEPTH);
    glyphs = pendingGlyphs();
    show = 1'b0;
    sepNow = 1'b0;
    if (mValid && mShownLast) sepNow = 1'b1;
    else if (mValid)          show = (mQ.size() > 0);
    else if (mPrevSep)        show = (glyphs > 0);
    else                      show = (glyphs > 0) || (mQ.size() == DEPTH);
    if (show) begin
      e = mQ.pop_front();
      mBits = e[3:1];
      mValid = 1'b1;
      mShownLast = e[0];
    end else begin
      mBits = 3'b000;
      mValid = 1'b0;
      mShownLast = 1'b0;
    end
    mPrevSep = sepNow;
    if (canAccept) begin
      mPix.push_back(p);
      if (mPix.size() == 3 || pl) begin
        col = 3'b000;
        foreach (mPix[i]) col[2-i] = mPix[i];
        mQ.push_back({col, pl});
        mPix.delete();
      end
    end
  endtask

  // Compare every DUT output against the model, away from the active edge.
  task automatic checkOutput();
    logic expReady;
    expReady = (mQ.size() < DEPTH);
    checks++;
    if (bits !== mBits) begin
      errors++;
      $display("[TB] FAIL bits @%0t: got %b expected %b", $time, bits, mBits);
    end
    checks++;
    if (col_valid !== mValid) begin
      errors++;
      $display("[TB] FAIL col_valid @%0t: got %b expected %b", $time, col_valid, mValid);
    end
    checks++;
    if (pixel_ready !== expReady) begin
      errors++;
      $display("[TB] FAIL pixel_ready @%0t: got %b expected %b", $time, pixel_ready, expReady);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic pv, input logic p, input logic pl,
                               output bit acc);
    restart = r;
    pixel_valid = pv;
    pixel = p;
    pixel_last = pl;
    acc = !r && pv && (mQ.size() < DEPTH);
    @(posedge clk);
    modelUpdate(r, pv, p, pl);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  // Pixels are taken MSB first from pat; lastAt is the index flagged pixel_last.
  task automatic sendPixels(input logic [31:0] pat, input int n, input int lastAt);
    bit acc;
    int tries;
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
        applyStimulus(1'b0, 1'b1, pat[n-1-i], (i == lastAt), acc);
        tries++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("[TB] FAIL send_timeout: pixel %0d got not-accepted expected accepted", i);
      end
    end
  endtask

  task automatic expectLit(input string name, input logic v, input logic [2:0] b);
    checks++;
    if (col_valid !== v || bits !== b) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%b bits=%b expected valid=%b bits=%b",
               name, col_valid, bits, v, b);
    end
  endtask

  task automatic expectReady(input string name, input logic r);
    checks++;
    if (pixel_ready !== r) begin
      errors++;
      $display("[TB] FAIL %s: got pixel_ready=%b expected %b", name, pixel_ready, r);
    end
  endtask

  task automatic expectCount(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    bit acc;
    int nValid, lastDiv;
    modelReset();
    restart = 1'b1;
    pixel_valid = 1'b0;
    pixel = 1'b0;
    pixel_last = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, acc);
    expectLit("reset_outputs", 1'b0, 3'b000);
    expectReady("reset_ready", 1'b1);
    idle(2);

    $display("[TB] L glyph");
    sendPixels(32'b111001000, 9, 8);
    expectLit("L_latency_blank", 1'b0, 3'b000);
    idle(1); expectLit("L_col0", 1'b1, 3'b111);
    idle(1); expectLit("L_col1", 1'b1, 3'b001);
    idle(1); expectLit("L_col2", 1'b1, 3'b000);
    idle(1); expectLit("L_sep", 1'b0, 3'b000);
    idle(3);

    $display("[TB] partial column");
    sendPixels(32'b1111, 4, 3);
    idle(1); expectLit("part_col0", 1'b1, 3'b111);
    idle(1); expectLit("part_col1", 1'b1, 3'b100);
    idle(1); expectLit("part_sep", 1'b0, 3'b000);
    idle(3);

    $display("[TB] back-to-back glyphs with coincident last push/pop");
    sendPixels(32'b111001000, 9, 8);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, acc); expectLit("b2b_A0", 1'b1, 3'b111);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, acc); expectLit("b2b_A1", 1'b1, 3'b001);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, acc); expectLit("b2b_A2", 1'b1, 3'b000);
    idle(1); expectLit("b2b_sep", 1'b0, 3'b000);
    idle(1); expectLit("b2b_B0", 1'b1, 3'b101);
    idle(1); expectLit("b2b_Bsep", 1'b0, 3'b000);
    idle(3);

    $display("[TB] fill and forced release");
    for (int i = 0; i < 24; i++) applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, acc);
    expectReady("fill_ready_low", 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, acc);
    expectLit("fill_first_valid", 1'b1, mBits);
    nValid = col_valid ? 1 : 0;
    for (int i = 0; i < 19; i++) begin
      idle(1);
      if (col_valid) nValid++;
    end
    expectCount("fill_released_columns", nValid, 8);
    expectLit("fill_back_idle", 1'b0, 3'b000);
    expectReady("fill_ready_back", 1'b1);

    $display("[TB] restart during emission");
    sendPixels(32'b111001000, 9, 8);
    idle(1); expectLit("rst_L_col0", 1'b1, 3'b111);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, acc);
    expectLit("rst_blank", 1'b0, 3'b000);
    expectReady("rst_ready", 1'b1);
    nValid = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (col_valid) nValid++;
    end
    expectCount("rst_no_leftovers", nValid, 0);

    $display("[TB] randomized traffic");
    for (int seg = 0; seg < 6; seg++) begin
      lastDiv = (seg % 2 == 0) ? 6 : 40;
      for (int i = 0; i < 500; i++) begin
        applyStimulus(1'($urandom_range(0, 299) == 0),
                      1'($urandom_range(0, 9) < 7),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, lastDiv - 1) == 0),
                      acc);
      end
    end
    idle(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
